// File: rtl/pla_check_pkg.sv
// Shared types and constants for restricted-PLA sweep harnesses.
// Holds the FSM state type and MISR defaults.
package pla_check_pkg;

  localparam int PLA_N_IN = 13;

  localparam logic [15:0] PLA_SIG_POLY = 16'hB400;
  localparam logic [15:0] PLA_SIG_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pla_sweep_checker_if.sv
// Control, stimulus and result bundle of the PLA sweep checker.
// slave faces the checker, master faces the harness driving it.
interface pla_sweep_if #(
  parameter int N_IN  = 13,
  parameter int SIG_W = 16
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   x_out;
  logic              y_in;
  logic [N_IN:0]     onset_count;
  logic [N_IN-1:0]   first_onset;
  logic              first_valid;
  logic [SIG_W-1:0]  signature;

  modport slave (
    input  start, abort, y_in,
    output busy, done, x_out,
    output onset_count, first_onset,
    output first_valid, signature
  );

  modport master (
    output start, abort, y_in,
    input  busy, done, x_out,
    input  onset_count, first_onset,
    input  first_valid, signature
  );
endinterface

// File: rtl/pla_misr.sv
// Galois-style multiple-input signature register, one bit per cycle.
// load has priority over en; reset reloads the seed.
module pla_misr #(
  parameter int              SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] nxt;

  always_comb begin
    nxt = sig >> 1;
    if (sig[0] ^ din)
      nxt = nxt ^ SIG_POLY;
  end

  always_ff @(posedge clk) begin
    if (rst || load)
      sig <= seed;
    else if (en)
      sig <= nxt;
  end

endmodule

// File: rtl/pla_sweep_checker.sv
// Exhaustive sweep of an N_IN-input function with onset count,
// first onset minterm and MISR compaction of the responses.
module pla_sweep_checker
  import pla_check_pkg::*;
#(
  parameter int               N_IN     = PLA_N_IN,
  parameter int               LAT      = 0,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = PLA_SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_SEED = PLA_SIG_SEED
) (
  input logic         clk,
  input logic         rst,
  pla_sweep_if.slave  bus
);

  localparam int DW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [N_IN-1:0] X_LAST = '1;
  localparam logic [N_IN-1:0] X_ONE  = 1;
  localparam logic [N_IN:0]   C_ONE  = 1;
  localparam logic [DW-1:0]   D_ONE  = 1;
  localparam logic [DW-1:0]   D_LAST = DW'(LAT - 1);

  state_t          state;
  logic [N_IN-1:0] x;
  logic [DW-1:0]   dcnt;
  logic            go;
  logic            kill;
  logic            cons_v;
  logic [N_IN-1:0] cons_k;
  logic [N_IN:0]   cnt;
  logic [N_IN-1:0] first;
  logic            fv;

  assign go   = (state == IDLE) && bus.start && !bus.abort;
  assign kill = bus.abort &&
                (state == SWEEP || state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          state <= SWEEP;
          x     <= '0;
        end
        SWEEP: if (bus.abort) begin
          state <= IDLE;
        end else if (x == X_LAST) begin
          state <= (LAT > 0) ? DRAIN : DONE;
          dcnt  <= '0;
        end else begin
          x <= x + X_ONE;
        end
        DRAIN: if (bus.abort) begin
          state <= IDLE;
        end else if (dcnt == D_LAST) begin
          state <= DONE;
        end else begin
          dcnt <= dcnt + D_ONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Each issued vector carries its index so the response lines up
  // with the right minterm once it emerges LAT cycles later.
  generate
    if (LAT == 0) begin : g_comb
      assign cons_v = (state == SWEEP) && !bus.abort;
      assign cons_k = x;
    end else begin : g_tag
      logic [LAT-1:0]  tv;
      logic [N_IN-1:0] tk [LAT];

      always_ff @(posedge clk) begin
        if (rst || kill || go) begin
          tv <= '0;
          for (int i = 0; i < LAT; i++)
            tk[i] <= '0;
        end else begin
          tv[0] <= (state == SWEEP);
          tk[0] <= x;
          for (int i = 1; i < LAT; i++) begin
            tv[i] <= tv[i-1];
            tk[i] <= tk[i-1];
          end
        end
      end

      assign cons_v = tv[LAT-1] && !bus.abort;
      assign cons_k = tk[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || go) begin
      cnt   <= '0;
      first <= '0;
      fv    <= 1'b0;
    end else if (cons_v && bus.y_in) begin
      cnt <= cnt + C_ONE;
      if (!fv) begin
        first <= cons_k;
        fv    <= 1'b1;
      end
    end
  end

  pla_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .seed (SIG_SEED),
    .en   (cons_v),
    .din  (bus.y_in),
    .sig  (bus.signature)
  );

  assign bus.busy        = (state == SWEEP) || (state == DRAIN);
  assign bus.done        = (state == DONE);
  assign bus.x_out       = x;
  assign bus.onset_count = cnt;
  assign bus.first_onset = first;
  assign bus.first_valid = fv;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Bench for pla_sweep_checker: LAT=0 and LAT=2 instances run side by
// side against a truth-table model of the function under test.
module tb_pla_sweep_checker;
  import pla_check_pkg::*;

  localparam int N  = 13;
  localparam int NV = 8192;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  always #5 clk = ~clk;

  pla_sweep_if #(.N_IN(N), .SIG_W(16)) b0 ();
  pla_sweep_if #(.N_IN(N), .SIG_W(16)) b1 ();

  pla_sweep_checker #(.LAT(0)) u0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );
  pla_sweep_checker #(.LAT(2)) u2 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );

  bit   lut [NV];
  logic p1;
  logic p2;

  assign b0.start = start;
  assign b1.start = start;
  assign b0.abort = abort;
  assign b1.abort = abort;
  assign b0.y_in  = lut[b0.x_out];

  always @(posedge clk) begin
    p1 <= lut[b1.x_out];
    p2 <= p1;
  end
  assign b1.y_in = p2;

  int total = 0;
  int bad   = 0;

  int          e_cnt;
  int          e_first;
  bit          e_fv;
  logic [15:0] e_sig;

  logic [43:0] r0;
  logic [43:0] r1;
  logic [43:0] ex;
  assign r0 = {b0.onset_count, b0.first_onset,
               b0.first_valid, b0.signature};
  assign r1 = {b1.onset_count, b1.first_onset,
               b1.first_valid, b1.signature};

  function automatic bit fref(int k);
    int hi;
    hi = (k >> 9) & 15;
    return ((k & 'h1FF) == 'h170) &&
           ((hi & 3) == 3 || (hi & 12) == 12);
  endfunction

  task automatic model(input int stop);
    bit y;
    e_cnt = 0; e_first = 0; e_fv = 0; e_sig = 16'hFFFF;
    for (int k = 0; k < stop; k++) begin
      y = lut[k];
      if (y) begin
        e_cnt++;
        if (!e_fv) begin e_first = k; e_fv = 1; end
      end
      e_sig = (e_sig >> 1) ^
              (((e_sig & 1) != 0) != y ? 16'hB400 : 16'h0000);
    end
    ex = {14'(e_cnt), 13'(e_first), e_fv, e_sig};
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(input int extra, output int c0,
                           output int c1);
    c0 = 0; c1 = 0;
    pulse_start();
    for (int e = 1; e <= 9000 && (c0 == 0 || c1 == 0); e++) begin
      @(posedge clk); #1;
      if (b0.done && c0 == 0) c0 = e + 1;
      if (b1.done && c1 == 0) c1 = e + 1;
      if (extra != 0 && (e == extra || e == extra * 50))
        start = 1'b1;
      else
        start = 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [61:0] want;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    want = {2'b00, 13'd0, 14'd0, 13'd0, 1'b0, 16'hFFFF};
    total++;
    if ({b0.busy, b0.done, b0.x_out, r0} !== want) begin
      bad++;
      $display("FAIL reset_l0 got=%h exp=%h",
               {b0.busy, b0.done, b0.x_out, r0}, want);
    end
    total++;
    if ({b1.busy, b1.done, b1.x_out, r1} !== want) begin
      bad++;
      $display("FAIL reset_l2 got=%h exp=%h",
               {b1.busy, b1.done, b1.x_out, r1}, want);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_function;
    int c0, c1;
    for (int k = 0; k < NV; k++) lut[k] = fref(k);
    model(NV);
    run_sweep(0, c0, c1);
    total++;
    if (c0 != 8193) begin
      bad++; $display("FAIL fn_done_l0 got=%0d exp=8193", c0);
    end
    total++;
    if (c1 != 8195) begin
      bad++; $display("FAIL fn_done_l2 got=%0d exp=8195", c1);
    end
    total++;
    if (b0.onset_count !== 14'd7 || b0.first_onset !== 13'd1904
        || b0.first_valid !== 1'b1) begin
      bad++;
      $display("FAIL fn_const got=%0d/%0d/%0d exp=7/1904/1",
               b0.onset_count, b0.first_onset, b0.first_valid);
    end
    total++;
    if (r0 !== ex) begin
      bad++; $display("FAIL fn_l0 got=%h exp=%h", r0, ex);
    end
    total++;
    if (r1 !== ex) begin
      bad++; $display("FAIL fn_l2 got=%h exp=%h", r1, ex);
    end
  endtask

  task automatic test_ties;
    int c0, c1;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < NV; k++) lut[k] = (t == 1);
      model(NV);
      run_sweep(0, c0, c1);
      total++;
      if (b0.onset_count !== 14'(t * 8192) ||
          b0.first_onset !== 13'd0 ||
          b0.first_valid !== 1'(t)) begin
        bad++;
        $display("FAIL tie%0d got=%0d/%0d/%0d", t,
                 b0.onset_count, b0.first_onset, b0.first_valid);
      end
      total++;
      if (r0 !== ex || r1 !== ex) begin
        bad++;
        $display("FAIL tie%0d_sig got=%h/%h exp=%h", t, r0, r1, ex);
      end
    end
  endtask

  task automatic test_abort;
    int c0, c1;
    bit seen;
    for (int k = 0; k < NV; k++) lut[k] = fref(k);
    pulse_start();
    repeat (2999) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    total++;
    if (b0.busy !== 1'b0 || b1.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b%b exp=00", b0.busy, b1.busy);
    end
    @(negedge clk) abort = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b0.done || b1.done) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL abort_done got=1 exp=0");
    end
    model(2999);
    total++;
    if (r0 !== ex) begin
      bad++; $display("FAIL abort_part_l0 got=%h exp=%h", r0, ex);
    end
    total++;
    if (b1.onset_count !== 14'd1 || b1.first_onset !== 13'd1904 ||
        b1.first_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_part_l2 got=%0d/%0d exp=1/1904",
               b1.onset_count, b1.first_onset);
    end
    model(NV);
    run_sweep(0, c0, c1);
    total++;
    if (r0 !== ex || r1 !== ex || c0 != 8193 || c1 != 8195) begin
      bad++;
      $display("FAIL abort_restart got=%h/%h/%0d/%0d exp=%h",
               r0, r1, c0, c1, ex);
    end
  endtask

  task automatic test_reset_mid;
    int c0, c1;
    for (int k = 0; k < NV; k++)
      lut[k] = ($urandom_range(0, 7) == 0);
    pulse_start();
    repeat (1000) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({b0.busy, b0.done, b0.x_out, r0} !==
        {2'b00, 13'd0, 14'd0, 13'd0, 1'b0, 16'hFFFF} ||
        {b1.busy, b1.done, b1.x_out, r1} !==
        {2'b00, 13'd0, 14'd0, 13'd0, 1'b0, 16'hFFFF}) begin
      bad++;
      $display("FAIL midrst got=%h/%h", r0, r1);
    end
    @(negedge clk) rst = 1'b0;
    model(NV);
    run_sweep(100, c0, c1);
    total++;
    if (c0 != 8193 || c1 != 8195) begin
      bad++;
      $display("FAIL midrst_lat got=%0d/%0d exp=8193/8195", c0, c1);
    end
    total++;
    if (r0 !== ex || r1 !== ex) begin
      bad++;
      $display("FAIL midrst_res got=%h/%h exp=%h", r0, r1, ex);
    end
  endtask

  task automatic test_minterm;
    int c0, c1;
    for (int k = 0; k < NV; k++) lut[k] = (k == 8048);
    model(NV);
    run_sweep(0, c0, c1);
    total++;
    if (b0.onset_count !== 14'd1 || b0.first_onset !== 13'd8048
        || b1.first_onset !== 13'd8048) begin
      bad++;
      $display("FAIL minterm got=%0d/%0d/%0d exp=1/8048/8048",
               b0.onset_count, b0.first_onset, b1.first_onset);
    end
    total++;
    if (r0 !== ex || r1 !== ex) begin
      bad++;
      $display("FAIL minterm_sig got=%h/%h exp=%h", r0, r1, ex);
    end
  endtask

  task automatic test_random_idle;
    int c0, c1;
    int lo;
    lo = 4096 + $urandom_range(0, 4000);
    for (int k = 0; k < NV; k++)
      lut[k] = (k >= lo) && ($urandom_range(0, 3) == 0);
    model(NV);
    run_sweep(0, c0, c1);
    total++;
    if (r0 !== ex || r1 !== ex) begin
      bad++;
      $display("FAIL rand got=%h/%h exp=%h", r0, r1, ex);
    end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (b0.busy !== 1'b0 || b1.busy !== 1'b0 ||
        r0 !== ex || r1 !== ex) begin
      bad++;
      $display("FAIL idle_abort got=%b%b %h exp=00 %h",
               b0.busy, b1.busy, r0, ex);
    end
  endtask

  initial begin
    test_reset();
    test_function();
    test_ties();
    test_abort();
    test_reset_mid();
    test_minterm();
    test_random_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_sweep_checker.md
Name: pla_sweep_checker

Overview:
- Exhaustive stimulus and response stage for the 13-input, single-output restricted PLA functions produced by the mockturtle flow.
- Upstream side: drives every input vector 0..2^N_IN-1 into the function under test, one per cycle.
- Downstream side: consumes y0 and accumulates onset count, first onset minterm and a MISR signature.
- Lets the bench or silicon compare a restricted/optimised netlist against its golden PLA without per-vector readback.

Parameters:
N_IN, 13, input count of function under test; x_out width.
LAT, 0, pipeline latency in cycles from x_out to y_in (0 = purely combinational FUT).
SIG_W, 16, signature register width.
SIG_POLY, 16'hB400, Galois MISR feedback mask.
SIG_SEED, 16'hFFFF, signature value loaded on start.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a sweep when idle.
abort  input  1  cancels a running sweep.
busy  output  1  high from the cycle after accepted start until done.
done  output  1  one-cycle pulse when results become final.
x_out  output  N_IN  vector to function under test; bit i drives xi.
y_in  input  1  function output (y0), valid LAT cycles after x_out.
onset_count  output  N_IN+1  number of vectors with y_in=1.
first_onset  output  N_IN  lowest vector index with y_in=1.
first_valid  output  1  first_onset is meaningful.
signature  output  SIG_W  MISR over all responses in index order.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy=0, done=0, x_out=0, onset_count=0, first_onset=0, first_valid=0, signature=SIG_SEED, tag pipeline cleared. Reset mid-sweep discards everything; no done pulse.
- States: IDLE, SWEEP, DRAIN, DONE.
  - IDLE: start=1 -> SWEEP; clear counts and first_valid; signature<=SIG_SEED; x_out<=0.
  - SWEEP: x_out increments by 1 each cycle. On the cycle x_out = 2^N_IN-1, go to DRAIN if LAT>0, else DONE. x_out stays at 2^N_IN-1, never wraps.
  - DRAIN: exactly LAT cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Results hold in IDLE until the next accepted start.
- Sample tagging:
  - A valid bit plus index travels through a LAT-deep shift register alongside x_out.
  - y_in is consumed at a clk edge only when the tag at depth LAT is valid.
  - LAT=0: y_in is sampled at the same edge that advances x_out.
  - Exactly 2^N_IN samples are consumed per sweep.
- Per consumed sample, with index k and response y:
  - onset_count += y.
  - If y=1 and first_valid=0: first_onset<=k, first_valid<=1.
  - signature <= (signature>>1) XOR ((signature[0]^y) ? SIG_POLY : 0).
- Sweep latency: start accepted at edge 0; done high during cycle 2^N_IN+LAT+1 (8193 for defaults).
- start while busy or in DONE: ignored.
- abort in SWEEP/DRAIN: go to IDLE next edge, busy=0, no done. Partial results remain visible; first_valid unchanged.
- abort in IDLE: no effect.
- start and abort in the same IDLE cycle: abort wins, nothing starts.
- onset_count has N_IN+1 bits so all-ones (8192) cannot overflow.

Decomposition:
- Shared package pla_check_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - MISR defaults SIG_POLY and SIG_SEED;
  - the N_IN=13 constant used by all restricted-PLA harnesses.
- One natural sub-module: pla_misr (SIG_W, SIG_POLY; ports clk, rst, load, seed, en, din, sig). It is reused by other response compactors.

Test Plan:
- LAT=0; y_in = ~x0&~x1&~x2&~x3&x4&x5&x6&~x7&x8&((x9&x10)|(x11&x12)) -> onset_count=7, first_onset=1904, first_valid=1, done in cycle 8193, signature matches the bench model.
- LAT=2; same function through a 2-stage register -> identical onset_count, first_onset and signature to the LAT=0 run; done in cycle 8195.
- y_in tied 0 -> onset_count=0, first_valid=0, first_onset=0. y_in tied 1 -> onset_count=8192, first_onset=0.
- abort at sweep cycle 3000 -> busy falls next edge, no done; results are partial; a restart gives the full-sweep values.
- rst asserted mid-sweep, then start -> all outputs at reset values; the new sweep matches an uninterrupted run. Extra start pulses during busy change nothing.
- Single-minterm function y_in = (x_out==8048) -> onset_count=1, first_onset=8048.
